// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants and fetch-action decode
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  function automatic fetch_act_e fetch_action(input logic pcsrc, input logic stall);
    if (pcsrc)      return ACT_REDIRECT;
    else if (stall) return ACT_STALL;
    else            return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID bundle
interface fetch_stage_if #(
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic             stall;
  logic             PCsrc;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  instr;
  logic             valid;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  stall, PCsrc, target, imem_rdata,
    output imem_addr, PC, instr, valid, redirect_cnt
  );

  modport slave (
    output stall, PCsrc, target, imem_rdata,
    input  imem_addr, PC, instr, valid, redirect_cnt
  );

endinterface

// File: rtl/fetch_stage_pc_gen.sv
// rtl/fetch_stage_pc_gen.sv - program counter with redirect/stall next-PC mux
module pc_gen
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  fetch_act_e      act,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Low target bits are dropped silently; no misalignment trap exists here.
  always_comb begin
    pc_d = pc_q;
    unique case (act)
      ACT_REDIRECT: pc_d = target & ~32'h3;
      ACT_STALL:    pc_d = pc_q;
      default:      pc_d = pc_q + PC_INCR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, redirect counter
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  fetch_act_e       act;
  logic [XLEN-1:0]  pc_cur;

  logic [XLEN-1:0]  id_pc_d,    id_pc_q;
  logic [XLEN-1:0]  id_instr_d, id_instr_q;
  logic             id_valid_d, id_valid_q;
  logic [CNT_W-1:0] cnt_d,      cnt_q;

  assign act = fetch_action(bus.PCsrc, bus.stall);

  pc_gen #(.RESET_VECTOR(RESET_VECTOR)) u_pc_gen (
    .clk    (clk),
    .rst    (rst),
    .act    (act),
    .target (bus.target),
    .pc     (pc_cur)
  );

  always_comb begin
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    cnt_d      = cnt_q;
    unique case (act)
      ACT_REDIRECT: begin
        id_pc_d    = '0;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      ACT_STALL: ;
      default: begin
        id_pc_d    = pc_cur;
        id_instr_d = bus.imem_rdata;
        id_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_addr    = pc_cur;
  assign bus.PC           = id_pc_q;
  assign bus.instr        = id_instr_q;
  assign bus.valid        = id_valid_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  logic [31:0] m_pc, m_PC, m_instr;
  logic        m_valid;
  int          m_cnt;

  fetch_stage_if #(.CNT_W(CW)) bus ();

  fetch_stage #(.RESET_VECTOR(RV), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1);
  end

  task automatic model_reset();
    m_pc = RV; m_PC = 32'h0; m_instr = NOP; m_valid = 1'b0; m_cnt = 0;
  endtask

  // Applies the edge rules to the model using the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (bus.PCsrc) begin
      m_pc = {bus.target[31:2], 2'b00};
      m_PC = 32'h0; m_instr = NOP; m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!bus.stall) begin
      m_PC = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (bus.imem_addr !== RV) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, RV); end
    vectors++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.PC); end
    vectors++; if (bus.instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.instr, NOP); end
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    vectors++; if (bus.redirect_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.redirect_cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = RV + 32'(4 * i);
      vectors++; if (bus.PC !== exp) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.PC, exp); end
      vectors++; if (bus.instr !== mem_word(exp)) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, bus.instr, mem_word(exp)); end
      vectors++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, bus.valid); end
    end
    vectors++; if (bus.imem_addr !== 32'h10C) begin errors++; $display("FAIL seq_addr: got %h expected 0000010c", bus.imem_addr); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus.PC !== 32'h108) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 00000108", i, bus.PC); end
      vectors++; if (bus.instr !== mem_word(32'h108)) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, bus.instr, mem_word(32'h108)); end
      vectors++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.valid); end
      vectors++; if (bus.imem_addr !== 32'h10C) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 0000010c", i, bus.imem_addr); end
    end
    bus.stall = 1'b0;
    tick();
    vectors++; if (bus.PC !== 32'h10C) begin errors++; $display("FAIL stall_resume_pc: got %h expected 0000010c", bus.PC); end
    vectors++; if (bus.imem_addr !== 32'h110) begin errors++; $display("FAIL stall_resume_addr: got %h expected 00000110", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    bus.PCsrc = 1'b1; bus.target = 32'h0000_2003;
    tick();
    bus.PCsrc = 1'b0;
    vectors++; if (bus.instr !== NOP) begin errors++; $display("FAIL redir_instr: got %h expected %h", bus.instr, NOP); end
    vectors++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", bus.valid); end
    vectors++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL redir_pc: got %h expected 0", bus.PC); end
    vectors++; if (bus.imem_addr !== 32'h2000) begin errors++; $display("FAIL redir_addr: got %h expected 00002000", bus.imem_addr); end
    vectors++; if (bus.redirect_cnt !== 2'd1) begin errors++; $display("FAIL redir_cnt: got %0d expected 1", bus.redirect_cnt); end
    tick();
    vectors++; if (bus.PC !== 32'h2000) begin errors++; $display("FAIL redir_next_pc: got %h expected 00002000", bus.PC); end
    vectors++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL redir_next_valid: got %b expected 1", bus.valid); end
    vectors++; if (bus.instr !== mem_word(32'h2000)) begin errors++; $display("FAIL redir_next_instr: got %h expected %h", bus.instr, mem_word(32'h2000)); end
  endtask

  task automatic test_stall_redirect();
    bus.stall = 1'b1; bus.PCsrc = 1'b1; bus.target = 32'h40;
    tick();
    bus.stall = 1'b0; bus.PCsrc = 1'b0;
    vectors++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL sr_addr: got %h expected 00000040", bus.imem_addr); end
    vectors++; if (bus.valid !== 1'b0 || bus.instr !== NOP || bus.PC !== 32'h0) begin
      errors++; $display("FAIL sr_bubble: got valid=%b instr=%h pc=%h expected valid=0 instr=%h pc=0", bus.valid, bus.instr, bus.PC, NOP); end
    vectors++; if (bus.redirect_cnt !== 2'd2) begin errors++; $display("FAIL sr_cnt: got %0d expected 2", bus.redirect_cnt); end
  endtask

  task automatic test_wrap_saturate();
    bus.PCsrc = 1'b1; bus.target = 32'hFFFF_FFFC;
    tick();
    bus.PCsrc = 1'b0;
    tick();
    vectors++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", bus.imem_addr); end
    vectors++; if (bus.PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", bus.PC); end
    for (int i = 0; i < 2; i++) begin
      bus.PCsrc = 1'b1; bus.target = $urandom;
      tick();
      vectors++; if (bus.redirect_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected 3", i, bus.redirect_cnt); end
    end
    bus.PCsrc = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.PCsrc = 1'b1; bus.target = 32'h2000;
    tick();
    bus.PCsrc = 1'b0;
    repeat (4) tick();
    vectors++; if (bus.imem_addr !== 32'h2010) begin errors++; $display("FAIL ar_run_addr: got %h expected 00002010", bus.imem_addr); end
    bus.PCsrc = 1'b1; bus.stall = 1'b1; bus.target = 32'h3000;
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.imem_addr !== RV) begin errors++; $display("FAIL ar_addr: got %h expected %h", bus.imem_addr, RV); end
    vectors++; if (bus.PC !== 32'h0 || bus.instr !== NOP || bus.valid !== 1'b0) begin
      errors++; $display("FAIL ar_ifid: got pc=%h instr=%h valid=%b expected pc=0 instr=%h valid=0", bus.PC, bus.instr, bus.valid, NOP); end
    vectors++; if (bus.redirect_cnt !== 2'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", bus.redirect_cnt); end
    @(negedge clk);
    bus.PCsrc = 1'b0; bus.stall = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    vectors++; if (bus.PC !== RV || bus.valid !== 1'b1) begin errors++; $display("FAIL ar_resume: got pc=%h valid=%b expected pc=%h valid=1", bus.PC, bus.valid, RV); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.PCsrc  = ($urandom_range(0, 7) == 0);
      bus.stall  = ($urandom_range(0, 3) == 0);
      bus.target = $urandom;
      tick();
      vectors++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, bus.imem_addr, m_pc); end
      vectors++; if (bus.PC !== m_PC) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, bus.PC, m_PC); end
      vectors++; if (bus.instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, bus.instr, m_instr); end
      vectors++; if (bus.valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.valid, m_valid); end
      vectors++; if (int'(bus.redirect_cnt) !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bus.redirect_cnt, m_cnt); end
    end
    bus.PCsrc = 1'b0; bus.stall = 1'b0;
  endtask

  initial begin
    vectors = 0; errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.PCsrc = 1'b0; bus.target = 32'h0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
